// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue/writeback stage around an external 8-bit combinational ALU
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   instr_valid/instr_ready    instruction handshake; ready only in IDLE
//   instr_opcode/rs1/rs2/rd/wb instruction fields, sampled on the handshake
//   ld_valid/ld_addr/ld_data   external register-file write port, honoured in every state
//   rd_addr/rd_data            combinational debug read of the register file
//   alu_opcode/alu_op1/alu_op2 registered drive to the ALU, loaded in FETCH
//   alu_res/alu_c/alu_ac/alu_s ALU outputs, captured at the end of EXEC (EXEC2)
//   result/flags               last captured result and {C, AC, Z, S}
//   done                       high for the single WB cycle of each instruction
//
// Build option: define ALU_OUT_REG_EN to insert an EXEC2 state so the ALU gets
// two full cycles before its outputs are captured.
module alu_op_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_opcode,
    input  logic [AW-1:0] instr_rs1,
    input  logic [AW-1:0] instr_rs2,
    input  logic [AW-1:0] instr_rd,
    input  logic          instr_wb,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [2:0]    alu_opcode,
    output logic [7:0]    alu_op1,
    output logic [7:0]    alu_op2,
    input  logic [7:0]    alu_res,
    input  logic          alu_c,
    input  logic          alu_ac,
    input  logic          alu_s,
    output logic [7:0]    result,
    output logic [3:0]    flags,
    output logic          done
);
`ifdef ALU_OUT_REG_EN
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, EXEC2, WB} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;
`endif
    state_t state, state_nx;
    logic [2:0] op_q;
    logic [AW-1:0] rs1_q, rs2_q, rd_q;
    logic wb_q;
    logic capture;
    logic [7:0] regs [DEPTH];

    assign instr_ready = state == IDLE;
    assign done = state == WB;
    assign rd_data = regs[rd_addr];
`ifdef ALU_OUT_REG_EN
    assign capture = state == EXEC2;
`else
    assign capture = state == EXEC;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = instr_valid ? FETCH : IDLE;
            FETCH: state_nx = EXEC;
`ifdef ALU_OUT_REG_EN
            EXEC:  state_nx = EXEC2;
            EXEC2: state_nx = WB;
`else
            EXEC:  state_nx = WB;
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            wb_q       <= 1'b0;
            alu_opcode <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            result     <= '0;
            flags      <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && instr_valid) begin
                op_q  <= instr_opcode;
                rs1_q <= instr_rs1;
                rs2_q <= instr_rs2;
                rd_q  <= instr_rd;
                wb_q  <= instr_wb;
            end
            if (state == FETCH) begin
                alu_opcode <= op_q;
                alu_op1    <= regs[rs1_q];
                alu_op2    <= regs[rs2_q];
            end
            if (capture) begin
                result   <= alu_res;
                flags[1] <= alu_res == 8'h00;
                // only ADD (000) and SUB (001) touch C, AC and S
                if (op_q[2:1] == 2'b00) begin
                    flags[3] <= alu_c;
                    flags[2] <= alu_ac;
                    flags[0] <= alu_s;
                end
            end
        end
    end

    // writeback is placed after the load so it wins on an address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (ld_valid) regs[ld_addr] <= ld_data;
            if (state == WB && wb_q) regs[rd_q] <= result;
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized and directed bench for alu_op_sequencer with a behavioural ALU and reference model
module tb_alu_op_sequencer;
`ifdef ALU_OUT_REG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int PER = LAT + 1;

    logic clk = 1'b0, rst_n = 1'b0;
    logic instr_valid = 1'b0, instr_ready, instr_wb = 1'b0;
    logic [2:0] instr_opcode = '0;
    logic [3:0] instr_rs1 = '0, instr_rs2 = '0, instr_rd = '0;
    logic ld_valid = 1'b0;
    logic [3:0] ld_addr = '0, rd_addr = '0;
    logic [7:0] ld_data = '0, rd_data;
    logic [2:0] alu_opcode;
    logic [7:0] alu_op1, alu_op2, alu_res, result;
    logic alu_c, alu_ac, alu_s, done;
    logic [3:0] flags;

    int n_cmp = 0, n_err = 0;
    logic [7:0] mem [16];
    logic [7:0] m_res;
    logic [3:0] m_flags;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .instr_rd(instr_rd), .instr_wb(instr_wb),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_res(alu_res), .alu_c(alu_c), .alu_ac(alu_ac), .alu_s(alu_s),
        .result(result), .flags(flags), .done(done)
    );

    // returns {res, c, ac, s}
    function automatic logic [10:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] t;
        logic [7:0] r;
        logic c, ac;
        c = 1'b0;
        ac = 1'b0;
        r = a ^ b;
        case (op)
            3'd0: begin
                t = {1'b0, a} + {1'b0, b};
                r = t[7:0];
                c = t[8];
                ac = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
            end
            3'd1, 3'd2: begin
                r = a - b;
                c = a < b;
                ac = a[3:0] < b[3:0];
            end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = ~(a & b);
            3'd6: r = ~(a | b);
            default: r = a ^ b;
        endcase
        return {r, c, ac, r[7]};
    endfunction

    assign {alu_res, alu_c, alu_ac, alu_s} = alu_fn(alu_opcode, alu_op1, alu_op2);

    function automatic void model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                  input logic [3:0] d, input logic w, input bit fld,
                                  input logic [3:0] fa, input logic [7:0] fd);
        logic [10:0] v;
        v = alu_fn(op, mem[a], mem[b]);
        if (fld) mem[fa] = fd;
        m_res = v[10:3];
        m_flags[1] = v[10:3] == 8'h00;
        if (op == 3'd0 || op == 3'd1) {m_flags[3], m_flags[2], m_flags[0]} = v[2:0];
        if (w) mem[d] = m_res;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        m_res = 8'h00;
        m_flags = 4'h0;
    endfunction

    task automatic load(input logic [3:0] a, input logic [7:0] v);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_addr = a;
        ld_data = v;
        @(negedge clk);
        ld_valid = 1'b0;
        mem[a] = v;
    endtask

    task automatic start(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input logic w);
        @(negedge clk);
        instr_opcode = op;
        instr_rs1 = a;
        instr_rs2 = b;
        instr_rd = d;
        instr_wb = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    // optional load during FETCH; reports latency in cycles to done, captured outputs and rd after WB
    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input logic w, input bit fld,
                         input logic [3:0] fa, input logic [7:0] fd,
                         output int lat, output logic [7:0] o_res, output logic [3:0] o_flg,
                         output logic [7:0] o_rd, output logic o_done_after);
        start(op, a, b, d, w);
        if (fld) begin
            ld_valid = 1'b1;
            ld_addr = fa;
            ld_data = fd;
        end
        lat = -1;
        o_res = 8'hxx;
        o_flg = 4'hx;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) ld_valid = 1'b0;
            if (done) begin
                lat = k;
                o_res = result;
                o_flg = flags;
                break;
            end
        end
        ld_valid = 1'b0;
        rd_addr = d;
        @(negedge clk);
        o_rd = rd_data;
        o_done_after = done;
    endtask

    task automatic test_reset();
        start(3'd0, 4'd3, 4'd3, 4'd9, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if ({result, flags, done, alu_opcode, alu_op1, alu_op2} !== 36'h0) begin n_err++;
            $display("FAIL reset_outputs got res=%h flg=%h done=%b op=%h o1=%h o2=%h want all 0", result, flags, done, alu_opcode, alu_op1, alu_op2); end
        n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_low got %b want 1", instr_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", instr_ready); end
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_reg r%0d got %h want 00", i, rd_data); end
        end
    endtask

    task automatic test_add();
        int lat; logic [7:0] r, rd; logic [3:0] f; logic da;
        load(4'd1, 8'h0F);
        load(4'd2, 8'h01);
        model(3'd0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 4'd0, 8'h00);
        issue(3'd0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 4'd0, 8'h00, lat, r, f, rd, da);
        n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL add_latency got %0d want %0d", lat, LAT); end
        n_cmp++; if (r !== 8'h10) begin n_err++; $display("FAIL add_result got %h want 10", r); end
        n_cmp++; if (f !== 4'b0100) begin n_err++; $display("FAIL add_flags got %b want 0100", f); end
        n_cmp++; if (rd !== 8'h10) begin n_err++; $display("FAIL add_wb got %h want 10", rd); end
        n_cmp++; if (da !== 1'b0) begin n_err++; $display("FAIL add_done_pulse got %b want 0", da); end
    endtask

    task automatic test_sub();
        int lat; logic [7:0] r, rd; logic [3:0] f; logic da;
        load(4'd1, 8'h00);
        load(4'd2, 8'h01);
        model(3'd1, 4'd1, 4'd2, 4'd4, 1'b1, 1'b0, 4'd0, 8'h00);
        issue(3'd1, 4'd1, 4'd2, 4'd4, 1'b1, 1'b0, 4'd0, 8'h00, lat, r, f, rd, da);
        n_cmp++; if (r !== 8'hFF) begin n_err++; $display("FAIL sub_result got %h want ff", r); end
        n_cmp++; if (f !== 4'b1101) begin n_err++; $display("FAIL sub_flags got %b want 1101", f); end
        n_cmp++; if (rd !== 8'hFF) begin n_err++; $display("FAIL sub_wb got %h want ff", rd); end
    endtask

    task automatic test_flag_hold();
        int lat; logic [7:0] r, rd; logic [3:0] f; logic da;
        load(4'd1, 8'hFF);
        model(3'd0, 4'd1, 4'd2, 4'd5, 1'b1, 1'b0, 4'd0, 8'h00);
        issue(3'd0, 4'd1, 4'd2, 4'd5, 1'b1, 1'b0, 4'd0, 8'h00, lat, r, f, rd, da);
        n_cmp++; if ({r, f} !== {8'h00, 4'b1110}) begin n_err++; $display("FAIL hold_add got res=%h flg=%b want 00/1110", r, f); end
        load(4'd1, 8'hF0);
        load(4'd2, 8'h0F);
        model(3'd3, 4'd1, 4'd2, 4'd6, 1'b1, 1'b0, 4'd0, 8'h00);
        issue(3'd3, 4'd1, 4'd2, 4'd6, 1'b1, 1'b0, 4'd0, 8'h00, lat, r, f, rd, da);
        n_cmp++; if ({r, f} !== {8'h00, 4'b1110}) begin n_err++; $display("FAIL hold_and got res=%h flg=%b want 00/1110", r, f); end
        model(3'd4, 4'd1, 4'd2, 4'd7, 1'b1, 1'b0, 4'd0, 8'h00);
        issue(3'd4, 4'd1, 4'd2, 4'd7, 1'b1, 1'b0, 4'd0, 8'h00, lat, r, f, rd, da);
        n_cmp++; if ({r, f} !== {8'hFF, 4'b1100}) begin n_err++; $display("FAIL hold_or got res=%h flg=%b want ff/1100", r, f); end
    endtask

    task automatic test_back_to_back();
        int hs, first, gap, dn;
        load(4'd1, 8'h3C);
        load(4'd2, 8'hA5);
        model(3'd7, 4'd1, 4'd2, 4'd8, 1'b0, 1'b0, 4'd0, 8'h00);
        model(3'd7, 4'd1, 4'd2, 4'd8, 1'b0, 1'b0, 4'd0, 8'h00);
        hs = 0; first = -1; gap = -1; dn = 0;
        @(negedge clk);
        instr_opcode = 3'd7; instr_rs1 = 4'd1; instr_rs2 = 4'd2; instr_rd = 4'd8; instr_wb = 1'b0;
        instr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (done) dn++;
            if (instr_ready) begin
                if (hs == 0) first = i; else gap = i - first;
                hs++;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        n_cmp++; if (hs !== 2) begin n_err++; $display("FAIL b2b_handshakes got %0d want 2", hs); end
        n_cmp++; if (gap !== PER) begin n_err++; $display("FAIL b2b_spacing got %0d want %0d", gap, PER); end
        n_cmp++; if (dn !== 2) begin n_err++; $display("FAIL b2b_done_count got %0d want 2", dn); end
        n_cmp++; if ({result, flags} !== {m_res, m_flags}) begin n_err++;
            $display("FAIL b2b_result got %h/%b want %h/%b", result, flags, m_res, m_flags); end
    endtask

    task automatic test_wb_load();
        bit seen;
        model(3'd0, 4'd1, 4'd2, 4'd6, 1'b1, 1'b0, 4'd0, 8'h00);
        start(3'd0, 4'd1, 4'd2, 4'd6, 1'b1);
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL wbld_timeout got no done want done"); end
        ld_valid = 1'b1; ld_addr = 4'd6; ld_data = 8'hAA;
        @(negedge clk);
        ld_valid = 1'b0;
        rd_addr = 4'd6;
        #1;
        n_cmp++; if (rd_data !== mem[6]) begin n_err++; $display("FAIL wbld_collision got %h want %h", rd_data, mem[6]); end
    endtask

    task automatic test_random();
        int lat; logic [7:0] r, rd; logic [3:0] f; logic da;
        logic [2:0] op; logic [3:0] a, b, d, fa; logic w; bit fld; logic [7:0] fd;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) load(4'($urandom_range(0, 15)), 8'($urandom));
            op = 3'($urandom_range(0, 7));
            a = 4'($urandom_range(0, 15));
            b = ($urandom_range(0, 4) == 0) ? a : 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
            w = 1'($urandom);
            fld = $urandom_range(0, 3) == 0;
            fa = $urandom_range(0, 1) == 0 ? a : 4'($urandom_range(0, 15));
            fd = 8'($urandom);
            model(op, a, b, d, w, fld, fa, fd);
            issue(op, a, b, d, w, fld, fa, fd, lat, r, f, rd, da);
            n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL rnd%0d_latency got %0d want %0d", n, lat, LAT); end
            n_cmp++; if (r !== m_res) begin n_err++; $display("FAIL rnd%0d_result op=%0d got %h want %h", n, op, r, m_res); end
            n_cmp++; if (f !== m_flags) begin n_err++; $display("FAIL rnd%0d_flags op=%0d got %b want %b", n, op, f, m_flags); end
            n_cmp++; if (rd !== mem[d]) begin n_err++; $display("FAIL rnd%0d_reg r%0d got %h want %h", n, d, rd, mem[d]); end
        end
    endtask

    task automatic test_reset_exec();
        int dn;
        load(4'd1, 8'h12);
        load(4'd2, 8'h34);
        start(3'd0, 4'd1, 4'd2, 4'd7, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        dn = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        n_cmp++; if (dn !== 0) begin n_err++; $display("FAIL rstexec_done got %0d pulses want 0", dn); end
        rd_addr = 4'd7;
        #1;
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL rstexec_reg got %h want 00", rd_data); end
        n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL rstexec_result got %h want 00", result); end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_flag_hold();
        test_back_to_back();
        test_wb_load();
        test_random();
        test_reset_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
